// File: rtl/ibex_csr_pkg.sv
// ibex_csr_pkg: shared write-op encoding and staging states for the shadowed CSR bank.
package ibex_csr_pkg;
  localparam int CSR_OP_W = 2;
  typedef enum logic [CSR_OP_W-1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2,
    CSR_NONE  = 2'd3
  } csr_wr_op_e;
  typedef enum logic {ST_IDLE, ST_STAGED} csr_stage_e;
endpackage

// File: rtl/ibex_csr_shadow_cell.sv
// ibex_csr_shadow_cell: one CSR with inverted shadow copy, lock bit and sticky storage-mismatch flag.
module ibex_csr_shadow_cell #(
  parameter int               Width      = 32,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             lock_i,
  output logic [Width-1:0] q_o,
  output logic             locked_o,
  output logic             err_o
);
  logic [Width-1:0] shadow_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o      <= ResetValue;
      locked_o <= 1'b0;
    end else if (we_i) begin
      q_o      <= wdata_i;
      locked_o <= locked_o | lock_i;
    end
  end
  if (ShadowCopy) begin : g_sh
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_q <= ~ResetValue;
        err_o    <= 1'b0;
      end else begin
        if (we_i) shadow_q <= ~wdata_i;
        err_o <= err_o | (q_o != ~shadow_q);
      end
    end
  end else begin : g_nosh
    assign shadow_q = ~ResetValue;
    assign err_o    = 1'b0;
  end
endmodule

// File: rtl/ibex_csr_bank_shadowed.sv
// ibex_csr_bank_shadowed: bank of shadowed CSRs with WARL mask, set/clear ops, lock and
// optional two-phase commit; storage and update errors feed the alert logic.
module ibex_csr_bank_shadowed
  import ibex_csr_pkg::*;
#(
  parameter int                       NumRegs      = 4,
  parameter int                       Width        = 32,
  parameter bit                       ShadowCopy   = 1'b1,
  parameter bit                       StagedWrite  = 1'b1,
  parameter logic [NumRegs*Width-1:0] ResetValue   = '0,
  parameter logic [NumRegs*Width-1:0] WritableMask = '1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [(NumRegs > 1 ? $clog2(NumRegs) : 1)-1:0] addr_i,
  input  logic                                        wr_en_i,
  input  logic [CSR_OP_W-1:0]                         wr_op_i,
  input  logic [Width-1:0]                            wr_data_i,
  input  logic                                        lock_i,
  input  logic                                        abort_i,
  output logic [Width-1:0]                            rd_data_o,
  output logic [NumRegs*Width-1:0]                    regs_o,
  output logic [NumRegs-1:0]                          locked_o,
  output logic                                        staged_o,
  output logic                                        wr_done_o,
  output logic                                        wr_ignored_o,
  output logic                                        err_update_o,
  output logic                                        err_storage_o
);
  localparam int AW = NumRegs > 1 ? $clog2(NumRegs) : 1;
  csr_wr_op_e       op;
  csr_stage_e       state_q;
  logic [Width-1:0] regs [NumRegs];
  logic [Width-1:0] masks [NumRegs];
  logic [NumRegs-1:0] err_v;
  logic [Width-1:0] cur, msk, opr, nv, st_val_q, c_val;
  logic [AW-1:0]    st_addr_q, c_addr;
  logic             st_lock_q, c_lock;
  logic             in_range, ignore, abort, accept, second, match, commit;
  assign op       = csr_wr_op_e'(wr_op_i);
  assign in_range = int'(addr_i) < NumRegs;
  assign cur      = in_range ? regs[addr_i] : '0;
  assign msk      = in_range ? masks[addr_i] : '0;
  always_comb begin
    opr = op == CSR_WRITE ? wr_data_i : op == CSR_SET ? (cur | wr_data_i) : (cur & ~wr_data_i);
  end
  // Read-only bits always keep the current (reset) value.
  assign nv     = (opr & msk) | (cur & ~msk);
  assign ignore = !in_range || op == CSR_NONE || locked_o[addr_i];
  assign abort  = StagedWrite && state_q == ST_STAGED && abort_i;
  assign accept = wr_en_i && !ignore && !abort;
  assign second = state_q == ST_STAGED && accept;
  assign match  = addr_i == st_addr_q && nv == st_val_q;
  assign commit = StagedWrite ? (second && match) : accept;
  assign c_addr = StagedWrite ? st_addr_q : addr_i;
  assign c_val  = StagedWrite ? st_val_q : nv;
  assign c_lock = StagedWrite ? st_lock_q : lock_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      st_addr_q    <= '0;
      st_val_q     <= '0;
      st_lock_q    <= 1'b0;
      wr_done_o    <= 1'b0;
      wr_ignored_o <= 1'b0;
      err_update_o <= 1'b0;
    end else begin
      wr_done_o    <= commit;
      wr_ignored_o <= wr_en_i && ignore && !abort;
      err_update_o <= second && !match;
      if (abort) state_q <= ST_IDLE;
      else if (StagedWrite && accept) state_q <= state_q == ST_IDLE ? ST_STAGED : ST_IDLE;
      if (StagedWrite && accept && state_q == ST_IDLE) begin
        st_addr_q <= addr_i;
        st_val_q  <= nv;
        st_lock_q <= lock_i;
      end
    end
  end
  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    assign masks[i]                  = WritableMask[i*Width +: Width];
    assign regs_o[i*Width +: Width]  = regs[i];
    ibex_csr_shadow_cell #(
      .Width      (Width),
      .ShadowCopy (ShadowCopy),
      .ResetValue (ResetValue[i*Width +: Width])
    ) u_cell (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we_i     (commit && c_addr == AW'(i)),
      .wdata_i  (c_val),
      .lock_i   (c_lock),
      .q_o      (regs[i]),
      .locked_o (locked_o[i]),
      .err_o    (err_v[i])
    );
  end
  assign rd_data_o     = cur;
  assign staged_o      = state_q == ST_STAGED;
  assign err_storage_o = |err_v;
endmodule

// File: tb/tb_ibex_csr_bank_shadowed.sv
// tb_ibex_csr_bank_shadowed: directed scenarios checked every cycle against a behavioural bank model.
module tb_ibex_csr_bank_shadowed;
  localparam logic [127:0] RV = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
  localparam logic [127:0] WM = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic clk_i = 0, rst_i = 0;
  logic [1:0] addr_i = 0, wr_op_i = 0;
  logic wr_en_i = 0, lock_i = 0, abort_i = 0;
  logic [31:0] wr_data_i = 0, rd_data_o;
  logic [127:0] regs_o;
  logic [3:0] locked_o;
  logic staged_o, wr_done_o, wr_ignored_o, err_update_o, err_storage_o;
  int checks = 0, failures = 0;
  ibex_csr_bank_shadowed #(
    .NumRegs(4), .Width(32), .ShadowCopy(1'b1), .StagedWrite(1'b1),
    .ResetValue(RV), .WritableMask(WM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_en_i(wr_en_i), .wr_op_i(wr_op_i),
    .wr_data_i(wr_data_i), .lock_i(lock_i), .abort_i(abort_i), .rd_data_o(rd_data_o),
    .regs_o(regs_o), .locked_o(locked_o), .staged_o(staged_o), .wr_done_o(wr_done_o),
    .wr_ignored_o(wr_ignored_o), .err_update_o(err_update_o), .err_storage_o(err_storage_o)
  );
  always #5 clk_i = ~clk_i;
  // Behavioural model: register array, lock array, one pending-stage slot.
  logic [31:0] m_reg [4];
  logic [31:0] m_mask [4];
  logic [3:0] m_lock;
  logic m_stg, m_done, m_ign, m_uerr, m_serr, m_fault = 0;
  logic [1:0] s_addr;
  logic [31:0] s_val;
  logic s_lock;
  always @(posedge clk_i or posedge rst_i) begin
    logic [31:0] cur, r, nv;
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        m_reg[k] = RV[k*32 +: 32];
        m_mask[k] = WM[k*32 +: 32];
      end
      m_lock = 0; m_stg = 0; m_done = 0; m_ign = 0; m_uerr = 0; m_serr = 0; m_fault = 0;
    end else begin
      m_done = 0; m_ign = 0; m_uerr = 0;
      if (m_fault) m_serr = 1;
      if (m_stg && abort_i) m_stg = 0;
      else if (wr_en_i) begin
        if (m_lock[addr_i] || wr_op_i == 2'd3) m_ign = 1;
        else begin
          cur = m_reg[addr_i];
          r = wr_op_i == 2'd0 ? wr_data_i : wr_op_i == 2'd1 ? cur | wr_data_i : cur & ~wr_data_i;
          nv = (r & m_mask[addr_i]) | (cur & ~m_mask[addr_i]);
          if (!m_stg) begin
            m_stg = 1; s_addr = addr_i; s_val = nv; s_lock = lock_i;
          end else begin
            m_stg = 0;
            if (addr_i == s_addr && nv == s_val) begin
              m_reg[s_addr] = s_val;
              if (s_lock) m_lock[s_addr] = 1;
              m_done = 1;
            end else m_uerr = 1;
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("rd_data", rd_data_o, m_reg[addr_i]);
      for (int k = 0; k < 4; k++) chk("regs", regs_o[k*32 +: 32], m_reg[k]);
      chk("locked", 32'(locked_o), 32'(m_lock));
      chk("staged", 32'(staged_o), 32'(m_stg));
      chk("wr_done", 32'(wr_done_o), 32'(m_done));
      chk("wr_ignored", 32'(wr_ignored_o), 32'(m_ign));
      chk("err_update", 32'(err_update_o), 32'(m_uerr));
      chk("err_storage", 32'(err_storage_o), 32'(m_serr));
    end
  end
  task automatic wr(input logic [1:0] a, input logic [1:0] o, input logic [31:0] d, input logic l);
    @(posedge clk_i); #1;
    addr_i = a; wr_op_i = o; wr_data_i = d; lock_i = l; wr_en_i = 1;
    @(posedge clk_i); #1;
    wr_en_i = 0; lock_i = 0;
  endtask
  initial begin
    #2 rst_i = 1;
    #10 rst_i = 0;
    @(posedge clk_i); #1;
    for (int k = 0; k < 4; k++) begin
      addr_i = 2'(k); #1;
      chk("lit_reset_rd", rd_data_o, RV[k*32 +: 32]);
    end
    chk("lit_reset_flags", {26'd0, staged_o, err_update_o, err_storage_o, locked_o[0], locked_o[3], wr_done_o}, 32'd0);
    wr(2'd1, 2'd0, 32'hA5A5_0000, 0);
    chk("lit_staged_1st", 32'(staged_o), 32'd1);
    chk("lit_reg1_uncommitted", regs_o[63:32], 32'h1111_1111);
    wr(2'd1, 2'd0, 32'hA5A5_0000, 0);
    chk("lit_done_pulse", 32'(wr_done_o), 32'd1);
    chk("lit_reg1_commit", regs_o[63:32], 32'hA5A5_0000);
    @(posedge clk_i); #1;
    chk("lit_done_cleared", 32'(wr_done_o), 32'd0);
    wr(2'd2, 2'd0, 32'h1, 0);
    wr(2'd2, 2'd0, 32'h2, 0);
    chk("lit_err_update", 32'(err_update_o), 32'd1);
    chk("lit_reg2_kept", regs_o[95:64], 32'h2222_2222);
    chk("lit_idle_after_err", 32'(staged_o), 32'd0);
    wr(2'd0, 2'd1, 32'hFFFF_FFFF, 0);
    wr(2'd0, 2'd1, 32'hFFFF_FFFF, 0);
    chk("lit_set_masked", regs_o[31:0], 32'h0000_FFFF);
    wr(2'd0, 2'd2, 32'h0000_00FF, 0);
    wr(2'd0, 2'd2, 32'h0000_00FF, 0);
    chk("lit_clear_masked", regs_o[31:0], 32'h0000_FF00);
    wr(2'd0, 2'd1, 32'h0000_0010, 0);
    wr(2'd0, 2'd1, 32'h0000_0010, 0);
    chk("lit_set_reeval", regs_o[31:0], 32'h0000_FF10);
    wr(2'd1, 2'd0, 32'h5, 0);
    wr(2'd1, 2'd3, 32'h0, 0);
    chk("lit_none_ignored", 32'(wr_ignored_o), 32'd1);
    chk("lit_stage_kept", 32'(staged_o), 32'd1);
    wr(2'd1, 2'd0, 32'h5, 0);
    chk("lit_reg1_after_none", regs_o[63:32], 32'h5);
    wr(2'd2, 2'd0, 32'h9, 0);
    @(posedge clk_i); #1 abort_i = 1;
    @(posedge clk_i); #1 abort_i = 0;
    chk("lit_abort_idle", {30'd0, staged_o, err_update_o}, 32'd0);
    wr(2'd3, 2'd0, 32'h7, 1);
    wr(2'd3, 2'd0, 32'h7, 0);
    chk("lit_locked3", 32'(locked_o), 32'h8);
    wr(2'd3, 2'd0, 32'h0, 0);
    chk("lit_lock_ignored", 32'(wr_ignored_o), 32'd1);
    chk("lit_reg3_held", regs_o[127:96], 32'h7);
    force dut.g_reg[0].u_cell.shadow_q = 32'hFFFF_00EE;
    m_fault = 1;
    @(posedge clk_i); #1;
    release dut.g_reg[0].u_cell.shadow_q;
    chk("lit_storage_err", 32'(err_storage_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #1 chk("lit_storage_sticky", 32'(err_storage_o), 32'd1);
    wr(2'd1, 2'd0, 32'h3, 0);
    #1 rst_i = 1;
    #2 rst_i = 0;
    @(posedge clk_i); #1;
    chk("lit_rst_staged", 32'(staged_o), 32'd0);
    chk("lit_rst_storage", 32'(err_storage_o), 32'd0);
    chk("lit_rst_locked", 32'(locked_o), 32'd0);
    chk("lit_rst_reg1", regs_o[63:32], 32'h1111_1111);
    repeat (2) @(posedge clk_i);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
